// File: rtl/ccg_tt_pkg.sv
// Shared types and sizes for the truth-table capture block.
// CCG_TT_SIGNATURE_EN adds a fifth XOR-signature byte to the result stream.
package ccg_tt_pkg;

    localparam int N_IN  = 2;
    localparam int N_OUT = 8;
    localparam int N_VEC = 4;

`ifdef CCG_TT_SIGNATURE_EN
    localparam int N_BYTES = 5;
`else
    localparam int N_BYTES = 4;
`endif

    typedef logic [N_OUT-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        SEND,
        FIN
    } state_t;

endpackage

// File: rtl/ccg_tt_capture_if.sv
// Result byte stream between the capture block and its consumer.
// A byte moves on a rising edge where tt_valid and tt_ready are both 1; while
// tt_valid is 1 and tt_ready is 0 the producer holds tt_data unchanged.
interface ccg_tt_capture_if;

    ccg_tt_pkg::row_t tt_data;
    logic             tt_valid;
    logic             tt_ready;

    modport master (output tt_data, output tt_valid, input tt_ready);
    modport slave  (input tt_data, input tt_valid, output tt_ready);

endinterface

// File: rtl/ccg_tt_tx.sv
// Byte streamer: sends the captured rows (plus the XOR signature byte when
// CCG_TT_SIGNATURE_EN is defined) over the valid/ready result stream.
module ccg_tt_tx
    import ccg_tt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  row_t [N_VEC-1:0]        rows,
    ccg_tt_capture_if.master        tt,
    output logic                    last_sent
);

    localparam logic [2:0] LAST_IDX = 3'(N_BYTES - 1);

    logic [2:0] idx;
    logic       valid;
    row_t       byte_sel;

    // Rows are frozen during SEND, so a mux off idx keeps tt_data stable.
    always_comb begin
        byte_sel = rows[idx[1:0]];
`ifdef CCG_TT_SIGNATURE_EN
        if (idx == 3'd4) begin
            byte_sel = rows[0] ^ rows[1] ^ rows[2] ^ rows[3];
        end
`endif
    end

    assign tt.tt_data  = byte_sel;
    assign tt.tt_valid = valid;
    assign last_sent   = valid && tt.tt_ready && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            idx   <= 3'd0;
        end else if (go) begin
            valid <= 1'b1;
            idx   <= 3'd0;
        end else if (valid && tt.tt_ready) begin
            if (idx == LAST_IDX) begin
                valid <= 1'b0;
                idx   <= 3'd0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ccg_tt_capture.sv
// Truth-table capture: steps x through all input vectors, samples f after a
// settle time, then streams the rows. CCG_TT_SIGNATURE_EN adds a signature byte.
module ccg_tt_capture
    import ccg_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   x,
    input  logic [N_OUT-1:0]  f,
    output logic              busy,
    output logic              done,
    ccg_tt_capture_if.master  tt,
    output state_t            dbg_state
);

    state_t            state;
    logic [1:0]        v;
    logic [3:0]        cnt;
    row_t [N_VEC-1:0]  rows;
    logic              go;
    logic              last_sent;

    assign dbg_state = state;
    // Streamer is armed on the same edge the last row is stored.
    assign go = (state == SAMPLE) && (v == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            v     <= 2'd0;
            cnt   <= 4'd0;
            rows  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DRIVE;
                        v     <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                DRIVE: begin
                    x     <= v;
                    cnt   <= 4'(SETTLE_CYCLES - 1);
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                SAMPLE: begin
                    rows[v] <= f;
                    // Terminate at v==3 so the 2-bit index never wraps.
                    if (v != 2'd3) begin
                        v     <= v + 2'd1;
                        state <= DRIVE;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (last_sent) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ccg_tt_tx u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .rows      (rows),
        .tt        (tt),
        .last_sent (last_sent)
    );

endmodule

// File: tb/tb_ccg_tt_capture.sv
// Directed bench for ccg_tt_capture: sweeps, backpressure, mid-sweep reset,
// held start, and a SETTLE_CYCLES=1 instance probing the sample point.
module tb_ccg_tt_capture;
  import ccg_tt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: SETTLE_CYCLES = 2 ----------------
  logic       start = 1'b0;
  logic [1:0] x;
  logic [7:0] f;
  logic       busy, done;
  logic       ready = 1'b1;
  state_t     dbg_state;
  ccg_tt_capture_if tt_if ();
  assign tt_if.tt_ready = ready;
  assign f = 8'(x) * 8'h11 + 8'h01;

  ccg_tt_capture #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .f(f),
    .busy(busy), .done(done), .tt(tt_if), .dbg_state(dbg_state)
  );

  // ---------------- DUT 1: SETTLE_CYCLES = 1, f lags x by one cycle ----------------
  logic       start1 = 1'b0;
  logic [1:0] x1;
  logic [7:0] f1 = 8'h50;
  logic       busy1, done1;
  state_t     dbg_state1;
  ccg_tt_capture_if tt1_if ();
  assign tt1_if.tt_ready = 1'b1;
  always @(posedge clk) f1 <= 8'(x1) * 8'h11 + 8'h50;

  ccg_tt_capture #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .f(f1),
    .busy(busy1), .done(done1), .tt(tt1_if), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got1_q[$];
  logic [1:0] xs_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clk) begin
    #2;
    if (rst_n && tt_if.tt_valid && tt_if.tt_ready) got_q.push_back(tt_if.tt_data);
    if (rst_n && tt1_if.tt_valid) got1_q.push_back(tt1_if.tt_data);
    if (rst_n && dbg_state == SAMPLE) xs_q.push_back(x);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] sig);
    exp_q = {b0, b1, b2, b3};
    if (N_BYTES == 5) exp_q.push_back(sig);
  endtask

  task automatic compare_stream(input string tag, input bit second);
    int n;
    n = second ? got1_q.size() : got_q.size();
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) check($sformatf("%s_b%0d", tag, i), second ? 32'(got1_q[i]) : 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulses start, waits for done; optionally stalls 5 cycles on byte 0x23.
  task automatic run_sweep(input string tag, input bit bp, input int exp_cyc);
    int  cyc;
    bit  held;
    held = 1'b0;
    got_q.delete();
    xs_q.delete();
    build_exp(8'h01, 8'h12, 8'h23, 8'h34, 8'h04);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 300) begin
      if (bp && !held && tt_if.tt_valid && tt_if.tt_data == 8'h23) begin
        held  = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk); cyc++;
          check($sformatf("%s_hold_data%0d", tag, k), 32'(tt_if.tt_data), 32'h23);
          check($sformatf("%s_hold_valid%0d", tag, k), 32'(tt_if.tt_valid), 32'd1);
        end
        ready = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    compare_stream(tag, 1'b0);
    check({tag, "_nx"}, 32'(xs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < xs_q.size()) check($sformatf("%s_x%0d", tag, i), 32'(xs_q[i]), 32'(i));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_x_hold"}, 32'(x), 32'd3);
    check({tag, "_valid_idle"}, 32'(tt_if.tt_valid), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valid"}, 32'(tt_if.tt_valid), 32'd0);
    check({tag, "_data"}, 32'(tt_if.tt_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int base;
    base = 4 * (2 + 2) + N_BYTES + 1;

    #1;
    check_zero_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep("sweep", 1'b0, base);
    run_sweep("bp", 1'b1, base + 5);

    // Reset while settling vector 2.
    got_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(dbg_state == SETTLE && x == 2'd2) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("midrst_reached", 32'(cyc < 100), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_stream", 32'(got_q.size()), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    run_sweep("after_rst", 1'b0, base);

    // start held high across a sweep: one sweep, next accepted right after FIN.
    got_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("held_done_cyc", 32'(cyc), 32'(base));
    compare_stream("held", 1'b0);
    check("held_fin_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_idle_state", 32'(dbg_state), 32'(IDLE));
    check("held_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_restart_state", 32'(dbg_state), 32'(DRIVE));
    check("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("held_second_done", 32'(done), 32'd1);

    // SETTLE_CYCLES=1 instance: rows must show f after its one-cycle lag.
    got1_q.delete();
    build_exp(8'h50, 8'h61, 8'h72, 8'h83, 8'hC0);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("s1_done_cyc", 32'(cyc), 32'(4 * (1 + 2) + N_BYTES + 1));
    compare_stream("s1", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
